// File: rtl/cache_miss_ctrl_pkg.sv
// Shared types and parameter defaults for the cache miss controller.
package cache_miss_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StCompare,
        StWriteback,
        StFill
    } cache_state_t;

    localparam int unsigned NumSetsDef     = 4;
    localparam int unsigned LinesPerSetDef = 16;
    localparam int unsigned AddrBitsDef    = 32;
    localparam int unsigned LineBytesDef   = 32;

    // Tag width left over once index and line offset are removed from the address.
    function automatic int unsigned tag_bits(input int unsigned addr_bits,
                                             input int unsigned lines_per_set,
                                             input int unsigned line_bytes);
        return addr_bits - $clog2(lines_per_set) - $clog2(line_bytes);
    endfunction

endpackage

// File: rtl/cache_miss_ctrl_if.sv
// CPU, array/NMRU and physical-memory signals of the miss controller.
interface cache_miss_ctrl_if
    import cache_miss_ctrl_pkg::*;
#(
    parameter int unsigned num_sets      = NumSetsDef,
    parameter int unsigned lines_per_set = LinesPerSetDef,
    parameter int unsigned addr_bits     = AddrBitsDef,
    parameter int unsigned line_bytes    = LineBytesDef
);
    localparam int unsigned Idx = $clog2(lines_per_set);
    localparam int unsigned Tag = tag_bits(addr_bits, lines_per_set, line_bytes);

    // CPU side
    logic                 cpu_read;
    logic                 cpu_write;
    logic [addr_bits-1:0] cpu_addr;
    logic                 cpu_resp;

    // Tag/data/dirty arrays and NMRU
    logic [Idx-1:0]       index_lo;
    logic [num_sets-1:0]  hit_vector;
    logic [num_sets-1:0]  dirty_vector;
    logic [num_sets-1:0]  cache_replacement_select;
    logic [Tag-1:0]       victim_tag;
    logic [num_sets-1:0]  way_sel;
    logic                 data_load;
    logic                 fill_sel;
    logic                 tag_load;
    logic                 dirty_set;
    logic                 dirty_clr;
    logic                 cache_replacement_update;
    logic [num_sets-1:0]  update_vector;

    // Physical memory
    logic                 pmem_read;
    logic                 pmem_write;
    logic [addr_bits-1:0] pmem_addr;
    logic                 pmem_resp;

    modport ctrl (
        input  cpu_read, cpu_write, cpu_addr, hit_vector, dirty_vector,
               cache_replacement_select, victim_tag, pmem_resp,
        output cpu_resp, index_lo, way_sel, data_load, fill_sel, tag_load, dirty_set,
               dirty_clr, cache_replacement_update, update_vector, pmem_read, pmem_write,
               pmem_addr
    );

    modport env (
        output cpu_read, cpu_write, cpu_addr, hit_vector, dirty_vector,
               cache_replacement_select, victim_tag, pmem_resp,
        input  cpu_resp, index_lo, way_sel, data_load, fill_sel, tag_load, dirty_set,
               dirty_clr, cache_replacement_update, update_vector, pmem_read, pmem_write,
               pmem_addr
    );

endinterface

// File: rtl/cache_miss_ctrl_onehot_prio.sv
// Reduces a way vector to a single way: lowest set bit wins, empty selects way 0.
module cache_miss_ctrl_onehot_prio
    import cache_miss_ctrl_pkg::*;
#(
    parameter int unsigned num_sets = NumSetsDef
) (
    input  logic [num_sets-1:0] in_i,
    output logic [num_sets-1:0] out_o
);
    localparam logic [num_sets-1:0] One = num_sets'(1);

    // Isolate the lowest set bit via two's complement; fall back to way 0 when empty.
    always_comb begin
        out_o = in_i & (~in_i + One);
        if (in_i == '0) begin
            out_o = One;
        end
    end

endmodule

// File: rtl/cache_miss_ctrl.sv
// Hit/miss control FSM between the CPU port, the cache arrays and the NMRU block.
// A miss writes back a dirty victim, fills the line, then retries COMPARE so every
// completion and replacement update comes from the hit path.
module cache_miss_ctrl
    import cache_miss_ctrl_pkg::*;
#(
    parameter int unsigned num_sets      = NumSetsDef,
    parameter int unsigned lines_per_set = LinesPerSetDef,
    parameter int unsigned addr_bits     = AddrBitsDef,
    parameter int unsigned line_bytes    = LineBytesDef
) (
    input logic             clk,
    input logic             rst,
    cache_miss_ctrl_if.ctrl bus
);
    localparam int unsigned Idx = $clog2(lines_per_set);
    localparam int unsigned Off = $clog2(line_bytes);
    localparam logic [addr_bits-1:0] OffMask = addr_bits'((64'd1 << Off) - 64'd1);

    cache_state_t         state_q, state_d;
    logic [num_sets-1:0]  victim_q, victim_d;
    logic [num_sets-1:0]  hit_way;
    logic [num_sets-1:0]  sel_way;
    logic [Idx-1:0]       index;
    logic [addr_bits-1:0] line_addr;
    logic                 hit;

    assign index     = bus.cpu_addr[Off +: Idx];
    assign line_addr = bus.cpu_addr & ~OffMask;
    assign hit       = |bus.hit_vector;

    cache_miss_ctrl_onehot_prio #(
        .num_sets (num_sets)
    ) u_hit_prio (
        .in_i  (bus.hit_vector),
        .out_o (hit_way)
    );

    cache_miss_ctrl_onehot_prio #(
        .num_sets (num_sets)
    ) u_victim_prio (
        .in_i  (bus.cache_replacement_select),
        .out_o (sel_way)
    );

    // State and victim registers; reset abandons any miss in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            victim_q <= '0;
        end else begin
            state_q  <= state_d;
            victim_q <= victim_d;
        end
    end

    // Next state and all outputs decoded from the current state.
    always_comb begin
        state_d                      = state_q;
        victim_d                     = victim_q;
        bus.index_lo                 = index;
        bus.cpu_resp                 = 1'b0;
        bus.way_sel                  = '0;
        bus.data_load                = 1'b0;
        bus.fill_sel                 = 1'b0;
        bus.tag_load                 = 1'b0;
        bus.dirty_set                = 1'b0;
        bus.dirty_clr                = 1'b0;
        bus.cache_replacement_update = 1'b0;
        bus.update_vector            = '0;
        bus.pmem_read                = 1'b0;
        bus.pmem_write               = 1'b0;
        bus.pmem_addr                = '0;
        case (state_q)
            StIdle: begin
                if (bus.cpu_read || bus.cpu_write) begin
                    state_d = StCompare;
                end
            end
            StCompare: begin
                if (hit) begin
                    bus.way_sel                  = hit_way;
                    bus.cpu_resp                 = 1'b1;
                    bus.cache_replacement_update = 1'b1;
                    bus.update_vector            = hit_way;
                    if (bus.cpu_write) begin
                        bus.data_load = 1'b1;
                        bus.dirty_set = 1'b1;
                    end
                    state_d = StIdle;
                end else begin
                    victim_d = sel_way;
                    // Dirtiness judged on the sanitised victim, the way actually evicted.
                    state_d  = |(bus.dirty_vector & sel_way) ? StWriteback : StFill;
                end
            end
            StWriteback: begin
                bus.way_sel    = victim_q;
                bus.pmem_write = 1'b1;
                bus.pmem_addr  = {bus.victim_tag, index, {Off{1'b0}}};
                if (bus.pmem_resp) begin
                    bus.dirty_clr = 1'b1;
                    state_d       = StFill;
                end
            end
            StFill: begin
                bus.way_sel   = victim_q;
                bus.pmem_read = 1'b1;
                bus.pmem_addr = line_addr;
                if (bus.pmem_resp) begin
                    bus.data_load = 1'b1;
                    bus.fill_sel  = 1'b1;
                    bus.tag_load  = 1'b1;
                    state_d       = StCompare;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Flag illegal input conditions in simulation.
    always @(posedge clk) begin
        if (rst && state_q == StCompare) begin
            assert ($onehot0(bus.hit_vector))
                else $error("cache_miss_ctrl: multiple hit ways %b", bus.hit_vector);
        end
        if (rst && (state_q == StWriteback || state_q == StFill)) begin
            assert (bus.cpu_read || bus.cpu_write)
                else $error("cache_miss_ctrl: request dropped during miss handling");
        end
    end

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// Directed vector bench for cache_miss_ctrl with default parameters.
module tb_cache_miss_ctrl;

    typedef struct packed {
        logic        rst;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  hit;
        logic [3:0]  dirty;
        logic [3:0]  sel;
        logic [22:0] vtag;
        logic        resp;
    } in_t;

    typedef struct packed {
        logic        resp;
        logic [3:0]  idx;
        logic [3:0]  way;
        logic        dl;
        logic        fs;
        logic        tl;
        logic        ds;
        logic        dc;
        logic        upd;
        logic [3:0]  uv;
        logic        pr;
        logic        pw;
        logic [31:0] paddr;
    } out_t;

    typedef struct {
        string name;
        in_t   i;
        out_t  o;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_bad = 0;
    vec_t vecs[$];

    cache_miss_ctrl_if bus ();

    cache_miss_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic in_t mk_i(input logic r, input logic rd, input logic wr,
                                 input logic [31:0] a, input logic [3:0] h,
                                 input logic [3:0] d, input logic [3:0] s,
                                 input logic [22:0] t, input logic pr);
        return {r, rd, wr, a, h, d, s, t, pr};
    endfunction

    function automatic out_t mk_o(input logic resp, input logic [3:0] idx,
                                  input logic [3:0] way, input logic dl, input logic fs,
                                  input logic tl, input logic ds, input logic dc,
                                  input logic upd, input logic [3:0] uv, input logic pr,
                                  input logic pw, input logic [31:0] pa);
        return {resp, idx, way, dl, fs, tl, ds, dc, upd, uv, pr, pw, pa};
    endfunction

    function automatic out_t idle_o(input logic [3:0] idx);
        return mk_o(0, idx, 4'b0, 0, 0, 0, 0, 0, 0, 4'b0, 0, 0, 32'h0);
    endfunction

    function automatic string fmt(input out_t o);
        return $sformatf("resp=%b idx=%0d way=%b dl=%b fs=%b tl=%b ds=%b dc=%b upd=%b uv=%b pr=%b pw=%b addr=%h",
                         o.resp, o.idx, o.way, o.dl, o.fs, o.tl, o.ds, o.dc, o.upd, o.uv,
                         o.pr, o.pw, o.paddr);
    endfunction

    task automatic add(input string n, input in_t i, input out_t o);
        vec_t v;
        v.name = n;
        v.i    = i;
        v.o    = o;
        vecs.push_back(v);
    endtask

    task automatic drive(input in_t i);
        rst                          = i.rst;
        bus.cpu_read                 = i.rd;
        bus.cpu_write                = i.wr;
        bus.cpu_addr                 = i.addr;
        bus.hit_vector               = i.hit;
        bus.dirty_vector             = i.dirty;
        bus.cache_replacement_select = i.sel;
        bus.victim_tag               = i.vtag;
        bus.pmem_resp                = i.resp;
    endtask

    task automatic check(input string n, input out_t exp);
        out_t act;
        act = {bus.cpu_resp, bus.index_lo, bus.way_sel, bus.data_load, bus.fill_sel,
               bus.tag_load, bus.dirty_set, bus.dirty_clr, bus.cache_replacement_update,
               bus.update_vector, bus.pmem_read, bus.pmem_write, bus.pmem_addr};
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %s / want %s", n, fmt(act), fmt(exp));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    localparam logic [31:0] AddrA = 32'h0000_1267;  // idx 3, line 0x1260
    localparam logic [31:0] AddrB = 32'h0000_0040;  // idx 2
    localparam logic [31:0] AddrC = 32'h0000_01E0;  // idx 15
    localparam logic [31:0] AddrD = 32'hABCD_E0A4;  // idx 5, line 0xABCDE0A0
    localparam logic [31:0] AddrE = 32'h0000_0000;  // idx 0

    initial begin
        drive(mk_i(0, 0, 0, 32'h0, 4'h0, 4'h0, 4'h0, 23'h0, 0));

        // Reset state, request ignored while in reset.
        add("rst_idle",    mk_i(0, 0, 0, 32'h0, 4'h0, 4'h0, 4'h0, 23'h0, 0), idle_o(0));
        add("rst_req_ign", mk_i(0, 1, 0, AddrA, 4'h0, 4'h0, 4'h0, 23'h0, 0), idle_o(3));
        add("rst_release", mk_i(1, 0, 0, 32'h0, 4'h0, 4'h0, 4'h0, 23'h0, 0), idle_o(0));

        // Read miss, clean victim way 1, fill response after three cycles.
        add("t1_idle",  mk_i(1, 1, 0, AddrA, 4'h0, 4'h0, 4'b0010, 23'h0, 0), idle_o(3));
        add("t1_cmp",   mk_i(1, 1, 0, AddrA, 4'h0, 4'h0, 4'b0010, 23'h0, 0), idle_o(3));
        add("t1_fill0", mk_i(1, 1, 0, AddrA, 4'h0, 4'h0, 4'b0001, 23'h0, 0),
            mk_o(0, 3, 4'b0010, 0, 0, 0, 0, 0, 0, 4'b0, 1, 0, 32'h0000_1260));
        add("t1_fill1", mk_i(1, 1, 0, AddrA, 4'h0, 4'h0, 4'b0001, 23'h0, 0),
            mk_o(0, 3, 4'b0010, 0, 0, 0, 0, 0, 0, 4'b0, 1, 0, 32'h0000_1260));
        add("t1_fill2", mk_i(1, 1, 0, AddrA, 4'h0, 4'h0, 4'b0001, 23'h0, 1),
            mk_o(0, 3, 4'b0010, 1, 1, 1, 0, 0, 0, 4'b0, 1, 0, 32'h0000_1260));
        add("t1_hit",   mk_i(1, 1, 0, AddrA, 4'b0010, 4'h0, 4'h0, 23'h0, 0),
            mk_o(1, 3, 4'b0010, 0, 0, 0, 0, 0, 1, 4'b0010, 0, 0, 32'h0));
        add("t1_done",  mk_i(1, 0, 0, AddrA, 4'h0, 4'h0, 4'h0, 23'h0, 0), idle_o(3));

        // Read hit way 2.
        add("t2_idle", mk_i(1, 1, 0, AddrB, 4'b0100, 4'h0, 4'h0, 23'h0, 0), idle_o(2));
        add("t2_hit",  mk_i(1, 1, 0, AddrB, 4'b0100, 4'h0, 4'h0, 23'h0, 0),
            mk_o(1, 2, 4'b0100, 0, 0, 0, 0, 0, 1, 4'b0100, 0, 0, 32'h0));
        add("t2_done", mk_i(1, 0, 0, AddrB, 4'h0, 4'h0, 4'h0, 23'h0, 0), idle_o(2));

        // Write hit way 0.
        add("t3_idle", mk_i(1, 0, 1, AddrC, 4'b0001, 4'h0, 4'h0, 23'h0, 0), idle_o(15));
        add("t3_hit",  mk_i(1, 0, 1, AddrC, 4'b0001, 4'h0, 4'h0, 23'h0, 0),
            mk_o(1, 15, 4'b0001, 1, 0, 0, 1, 0, 1, 4'b0001, 0, 0, 32'h0));
        add("t3_done", mk_i(1, 0, 0, AddrC, 4'h0, 4'h0, 4'h0, 23'h0, 0), idle_o(15));

        // Read miss, dirty victim way 3 with tag 0x5A: writeback then fill.
        add("t4_idle", mk_i(1, 1, 0, AddrD, 4'h0, 4'b1000, 4'b1000, 23'h5A, 0), idle_o(5));
        add("t4_cmp",  mk_i(1, 1, 0, AddrD, 4'h0, 4'b1000, 4'b1000, 23'h5A, 0), idle_o(5));
        add("t4_wb0",  mk_i(1, 1, 0, AddrD, 4'h0, 4'b0001, 4'b0001, 23'h5A, 0),
            mk_o(0, 5, 4'b1000, 0, 0, 0, 0, 0, 0, 4'b0, 0, 1, 32'h0000_B4A0));
        add("t4_wb1",  mk_i(1, 1, 0, AddrD, 4'h0, 4'b0001, 4'b0001, 23'h5A, 1),
            mk_o(0, 5, 4'b1000, 0, 0, 0, 0, 1, 0, 4'b0, 0, 1, 32'h0000_B4A0));
        add("t4_fl0",  mk_i(1, 1, 0, AddrD, 4'h0, 4'h0, 4'h0, 23'h5A, 0),
            mk_o(0, 5, 4'b1000, 0, 0, 0, 0, 0, 0, 4'b0, 1, 0, 32'hABCD_E0A0));
        add("t4_fl1",  mk_i(1, 1, 0, AddrD, 4'h0, 4'h0, 4'h0, 23'h5A, 1),
            mk_o(0, 5, 4'b1000, 1, 1, 1, 0, 0, 0, 4'b0, 1, 0, 32'hABCD_E0A0));
        add("t4_hit",  mk_i(1, 1, 0, AddrD, 4'b1000, 4'h0, 4'h0, 23'h5A, 0),
            mk_o(1, 5, 4'b1000, 0, 0, 0, 0, 0, 1, 4'b1000, 0, 0, 32'h0));
        add("t4_done", mk_i(1, 0, 0, AddrD, 4'h0, 4'h0, 4'h0, 23'h0, 0), idle_o(5));

        // Write miss with non-one-hot select 0110: victim way 1; stray pmem_resp in IDLE.
        add("t6_idle", mk_i(1, 0, 1, AddrE, 4'h0, 4'h0, 4'b0110, 23'h0, 0), idle_o(0));
        add("t6_cmp",  mk_i(1, 0, 1, AddrE, 4'h0, 4'h0, 4'b0110, 23'h0, 0), idle_o(0));
        add("t6_fl0",  mk_i(1, 0, 1, AddrE, 4'h0, 4'h0, 4'h0, 23'h0, 0),
            mk_o(0, 0, 4'b0010, 0, 0, 0, 0, 0, 0, 4'b0, 1, 0, 32'h0));
        add("t6_fl1",  mk_i(1, 0, 1, AddrE, 4'h0, 4'h0, 4'h0, 23'h0, 1),
            mk_o(0, 0, 4'b0010, 1, 1, 1, 0, 0, 0, 4'b0, 1, 0, 32'h0));
        add("t6_hit",  mk_i(1, 0, 1, AddrE, 4'b0010, 4'h0, 4'h0, 23'h0, 0),
            mk_o(1, 0, 4'b0010, 1, 0, 0, 1, 0, 1, 4'b0010, 0, 0, 32'h0));
        add("t6_stray", mk_i(1, 0, 0, AddrE, 4'h0, 4'h0, 4'h0, 23'h0, 1), idle_o(0));
        add("t6_still", mk_i(1, 0, 0, AddrE, 4'h0, 4'h0, 4'h0, 23'h0, 0), idle_o(0));

        // All-zero select falls back to way 0, which is dirty.
        add("t7_idle", mk_i(1, 1, 0, AddrA, 4'h0, 4'b0001, 4'h0, 23'h1, 0), idle_o(3));
        add("t7_cmp",  mk_i(1, 1, 0, AddrA, 4'h0, 4'b0001, 4'h0, 23'h1, 0), idle_o(3));
        add("t7_wb0",  mk_i(1, 1, 0, AddrA, 4'h0, 4'h0, 4'h0, 23'h1, 0),
            mk_o(0, 3, 4'b0001, 0, 0, 0, 0, 0, 0, 4'b0, 0, 1, 32'h0000_0260));
        add("t7_wb1",  mk_i(1, 1, 0, AddrA, 4'h0, 4'h0, 4'h0, 23'h1, 1),
            mk_o(0, 3, 4'b0001, 0, 0, 0, 0, 1, 0, 4'b0, 0, 1, 32'h0000_0260));
        add("t7_fl0",  mk_i(1, 1, 0, AddrA, 4'h0, 4'h0, 4'h0, 23'h1, 0),
            mk_o(0, 3, 4'b0001, 0, 0, 0, 0, 0, 0, 4'b0, 1, 0, 32'h0000_1260));
        add("t7_fl1",  mk_i(1, 1, 0, AddrA, 4'h0, 4'h0, 4'h0, 23'h1, 1),
            mk_o(0, 3, 4'b0001, 1, 1, 1, 0, 0, 0, 4'b0, 1, 0, 32'h0000_1260));
        add("t7_hit",  mk_i(1, 1, 0, AddrA, 4'b0001, 4'h0, 4'h0, 23'h1, 0),
            mk_o(1, 3, 4'b0001, 0, 0, 0, 0, 0, 1, 4'b0001, 0, 0, 32'h0));
        add("t7_done", mk_i(1, 0, 0, AddrA, 4'h0, 4'h0, 4'h0, 23'h0, 0), idle_o(3));

        foreach (vecs[k]) begin
            @(negedge clk);
            drive(vecs[k].i);
            #1;
            check(vecs[k].name, vecs[k].o);
        end

        // Reset asserted mid-FILL: request drops at once, no tag update, clean restart.
        @(negedge clk);
        drive(mk_i(1, 1, 0, AddrB, 4'h0, 4'h0, 4'b0100, 23'h0, 0));
        #1 check("t5_idle", idle_o(2));
        @(negedge clk);
        #1 check("t5_cmp", idle_o(2));
        @(negedge clk);
        #1 check("t5_fill", mk_o(0, 2, 4'b0100, 0, 0, 0, 0, 0, 0, 4'b0, 1, 0, 32'h0000_0040));
        #2 rst = 1'b0;
        #1 check("t5_async_drop", idle_o(2));
        @(negedge clk);
        bus.pmem_resp = 1'b1;
        #1 check("t5_held", idle_o(2));
        @(negedge clk);
        bus.pmem_resp = 1'b0;
        bus.cpu_read  = 1'b0;
        #1 check("t5_in_rst", idle_o(2));
        @(negedge clk);
        rst = 1'b1;
        #1 check("t5_release", idle_o(2));
        @(negedge clk);
        drive(mk_i(1, 1, 0, AddrB, 4'b0100, 4'h0, 4'h0, 23'h0, 0));
        #1 check("t5_new_idle", idle_o(2));
        @(negedge clk);
        #1 check("t5_new_hit", mk_o(1, 2, 4'b0100, 0, 0, 0, 0, 0, 1, 4'b0100, 0, 0, 32'h0));
        @(negedge clk);
        bus.cpu_read = 1'b0;
        #1 check("t5_new_done", idle_o(2));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
